// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI-flash Wishbone read path.
// The FSM states, flash geometry and the READ opcode live here.
package spiflash_pkg;

  localparam int         FLASH_AW = 24;
  localparam int         WORD_W   = 32;
  localparam int         WORD_AW  = FLASH_AW - 2;
  localparam int         NBITS_W  = 6;
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    HOLD,
    DESEL
  } state_e;

  // Flash bytes arrive first-byte-in-MSB; the bus wants byte 0 in the low lane.
  function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_shifter.sv
// Mode-0 SPI bit engine: clock divider, 32-bit shift-out/shift-in and bit counter.
// A start on the cycle done is high chains the next transfer with no clock gap.
module spiflash_shifter
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NBITS_W-1:0] nbits,
  input  logic [WORD_W-1:0]  tx_word,
  output logic [WORD_W-1:0]  rx_word,
  output logic               done,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic              busy;
  logic [DIV_W-1:0]  div_cnt;
  logic [WORD_W-1:0] tx_sr;
  logic [4:0]        bits_left;
  logic              half_end;

  assign half_end = (div_cnt == DIV_LAST);
  assign done     = busy & sclk & half_end & (bits_left == 5'd0);
  assign mosi     = tx_sr[WORD_W-1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy      <= 1'b0;
      sclk      <= 1'b0;
      div_cnt   <= '0;
      tx_sr     <= '0;
      rx_word   <= '0;
      bits_left <= '0;
    end else if (abort) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      tx_sr   <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      sclk      <= 1'b0;
      div_cnt   <= '0;
      tx_sr     <= tx_word;
      bits_left <= 5'(nbits - NBITS_W'(1));
    end else if (busy) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          // Rising edge: the flash has held miso stable since the last fall.
          sclk    <= 1'b1;
          rx_word <= {rx_word[WORD_W-2:0], miso};
        end else begin
          sclk  <= 1'b0;
          tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
          if (bits_left == 5'd0) busy <= 1'b0;
          else                   bits_left <= bits_left - 5'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spiflash_wb_reader.sv
// Wishbone-classic read-only slave fetching words from SPI flash with READ (0x03).
// CS stays low after a word so a sequential fetch skips command and address.
module spiflash_wb_reader
  import spiflash_pkg::*;
#(
  parameter int CLK_DIV      = 1,
  parameter int CS_HIGH_MIN  = 4,
  parameter int HOLD_TIMEOUT = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [WORD_AW-1:0]  wb_adr_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic [WORD_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                spiflash_cs_n,
  output logic                spiflash_clk,
  output logic                spiflash_mosi,
  input  logic                spiflash_miso
);

  localparam int               CNT_MAX    = (CS_HIGH_MIN > HOLD_TIMEOUT) ? CS_HIGH_MIN : HOLD_TIMEOUT;
  localparam int               CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DESEL_LOAD = CNT_W'(CS_HIGH_MIN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [WORD_AW-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_d, err_d;
  logic [WORD_W-1:0]    dat_d;
  logic                 cs_n_d;

  logic                 req, rd_req, wr_req;
  logic                 start_cmd, start_data;
  logic                 sh_start, sh_abort, sh_done;
  logic [NBITS_W-1:0]   sh_nbits;
  logic [WORD_W-1:0]    sh_tx, sh_rx;
  logic                 unused_sel;

  assign unused_sel = ^wb_sel_i;

  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign rd_req = req & ~wb_we_i;
  assign wr_req = req &  wb_we_i;

  spiflash_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (sh_start),
    .abort   (sh_abort),
    .nbits   (sh_nbits),
    .tx_word (sh_tx),
    .rx_word (sh_rx),
    .done    (sh_done),
    .miso    (spiflash_miso),
    .sclk    (spiflash_clk),
    .mosi    (spiflash_mosi)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = wb_dat_o;
    start_cmd  = 1'b0;
    start_data = 1'b0;
    sh_start   = 1'b0;
    sh_abort   = 1'b0;
    sh_nbits   = NBITS_W'(WORD_W);
    sh_tx      = '0;

    case (state_q)
      IDLE: begin
        err_d = wr_req;
        if (rd_req) start_cmd = 1'b1;
      end
      CMD, ADDR, DATA: begin
        if (!wb_cyc_i) begin
          // Master gave up: park the clock low and discard the partial word.
          sh_abort = 1'b1;
          state_d  = DESEL;
          cnt_d    = DESEL_LOAD;
        end else if (sh_done) begin
          if (state_q == CMD) begin
            sh_start = 1'b1;
            sh_nbits = NBITS_W'(FLASH_AW);
            sh_tx    = {addr_q, 2'b00, 8'h00};
            state_d  = ADDR;
          end else if (state_q == ADDR) begin
            start_data = 1'b1;
          end else begin
            ack_d   = 1'b1;
            dat_d   = swap_bytes(sh_rx);
            addr_d  = addr_q + WORD_AW'(1);
            cnt_d   = HOLD_LOAD;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (wr_req) begin
          err_d = 1'b1;
          cnt_d = HOLD_LOAD;
        end else if (rd_req && wb_adr_i == addr_q) begin
          start_data = 1'b1;
        end else if (rd_req || cnt_q == '0) begin
          state_d = DESEL;
          cnt_d   = DESEL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DESEL: begin
        err_d = wr_req;
        if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
        else if (rd_req) start_cmd = 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = DESEL;
    endcase

    if (start_cmd) begin
      addr_d   = wb_adr_i;
      sh_start = 1'b1;
      sh_nbits = NBITS_W'(8);
      sh_tx    = {CMD_READ, 24'h000000};
      state_d  = CMD;
    end
    if (start_data) begin
      sh_start = 1'b1;
      state_d  = DATA;
    end

    cs_n_d = (state_d == IDLE) || (state_d == DESEL);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= DESEL;
      addr_q        <= '0;
      cnt_q         <= DESEL_LOAD;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_dat_o      <= '0;
      spiflash_cs_n <= 1'b1;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      wb_ack_o      <= ack_d;
      wb_err_o      <= err_d;
      wb_dat_o      <= dat_d;
      spiflash_cs_n <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_spiflash_wb_reader.sv
// Bench for spiflash_wb_reader: behavioural mode-0 READ flash, Wishbone master
// tasks and an ack-data scoreboard.
module tb_spiflash_wb_reader;

  localparam int CLK_DIV      = 1;
  localparam int CS_HIGH_MIN  = 4;
  localparam int HOLD_TIMEOUT = 32;
  localparam int FRESH_LAT    = 2 + 128 * CLK_DIV;
  localparam int CONT_LAT     = 2 + 64 * CLK_DIV;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [21:0] wb_adr_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        spiflash_cs_n, spiflash_clk, spiflash_mosi;
  logic        spiflash_miso = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  always #5 sys_clk = ~sys_clk;

  spiflash_wb_reader #(
    .CLK_DIV(CLK_DIV), .CS_HIGH_MIN(CS_HIGH_MIN), .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_adr_i(wb_adr_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .spiflash_cs_n(spiflash_cs_n), .spiflash_clk(spiflash_clk),
    .spiflash_mosi(spiflash_mosi), .spiflash_miso(spiflash_miso)
  );

  // Flash contents: low byte of the address, mixed with the upper bits.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], 4'h0} ^ a[23:16];
  endfunction

  // Behavioural flash: shift in 32 command/address bits on rising edges,
  // then drive data MSB first on falling edges with 24-bit address wrap.
  logic [31:0] f_in = '0;
  int          f_rx = 0;
  int          f_opos = 0;
  logic [23:0] f_addr = '0;
  logic [7:0]  f_cmd = '0;
  logic [23:0] f_cmd_addr = '0;
  logic [7:0]  f_byte;
  int          f_cmds = 0;
  int          sclk_rises = 0;
  logic        f_clk_prev = 1'b0;

  always @(spiflash_clk or spiflash_cs_n) begin
    if (spiflash_clk && !f_clk_prev) begin
      sclk_rises++;
      if (!spiflash_cs_n && f_rx < 32) begin
        f_in = {f_in[30:0], spiflash_mosi};
        f_rx++;
        if (f_rx == 32) begin
          f_cmd      = f_in[31:24];
          f_cmd_addr = f_in[23:0];
          f_addr     = f_in[23:0];
          f_opos     = 0;
          f_cmds++;
        end
      end
    end else if (!spiflash_clk && f_clk_prev && !spiflash_cs_n && f_rx == 32) begin
      f_byte = mem_byte(f_addr);
      spiflash_miso = f_byte[3'(7 - f_opos)];
      if (f_opos == 7) begin
        f_opos = 0;
        f_addr = f_addr + 24'd1;
      end else begin
        f_opos++;
      end
    end
    if (spiflash_cs_n) begin
      f_rx   = 0;
      f_opos = 0;
    end
    f_clk_prev = spiflash_clk;
  end

  // Monitors sampled mid-cycle: ack data capture, mode-0 and bus-protocol rules.
  int   mode0_viol = 0;
  int   proto_viol = 0;
  int   cs_run = 0;
  int   last_cs_high = 0;
  logic mosi_prev = 1'b0, ack_prev = 1'b0, err_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (wb_ack_o) obs_q.push_back(wb_dat_o);
      if (spiflash_clk && spiflash_mosi !== mosi_prev) mode0_viol++;
      if ((wb_ack_o && wb_err_o) || (wb_ack_o && ack_prev) || (wb_err_o && err_prev))
        proto_viol++;
      if (spiflash_cs_n) cs_run++;
      else begin
        if (cs_run > 0) last_cs_high = cs_run;
        cs_run = 0;
      end
    end
    mosi_prev = spiflash_mosi;
    ack_prev  = wb_ack_o;
    err_prev  = wb_err_o;
  end

  task automatic bus_cycle(input logic we, input logic [21:0] adr,
                           output int lat, output logic got_ack, output logic got_err);
    @(posedge sys_clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (lat < 2000 && !got_ack && !got_err) begin
      @(negedge sys_clk);
      lat++;
      got_ack = wb_ack_o;
      got_err = wb_err_o;
    end
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({spiflash_cs_n, spiflash_clk, spiflash_mosi, wb_ack_o, wb_err_o, wb_dat_o} !== {5'b10000, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs: cs_n=%b clk=%b mosi=%b ack=%b err=%b dat=%h want 1 0 0 0 0 00000000",
               spiflash_cs_n, spiflash_clk, spiflash_mosi, wb_ack_o, wb_err_o, wb_dat_o);
    end
    @(negedge sys_clk); sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
  endtask

  task automatic test_fresh_read();
    int lat, r0, c0; logic a, e; logic [31:0] obs, expd;
    r0 = sclk_rises; c0 = f_cmds;
    exp_q.push_back(32'h03020100);
    bus_cycle(1'b0, 22'h0, lat, a, e);
    checks++;
    if (!a || lat != FRESH_LAT) begin failures++; $display("FAIL fresh_latency: ack=%0b lat=%0d want %0d", a, lat, FRESH_LAT); end
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (obs !== expd) begin failures++; $display("FAIL fresh_data: got %h want %h", obs, expd); end
    checks++;
    if (f_cmd !== 8'h03 || f_cmd_addr !== 24'h000000 || f_cmds - c0 != 1) begin
      failures++; $display("FAIL fresh_cmd_addr: cmd=%h addr=%h cmds=%0d want 03 000000 1", f_cmd, f_cmd_addr, f_cmds - c0);
    end
    checks++;
    if (sclk_rises - r0 != 64) begin failures++; $display("FAIL fresh_sclk_count: got %0d want 64", sclk_rises - r0); end
    checks++;
    if (spiflash_cs_n !== 1'b0) begin failures++; $display("FAIL fresh_cs_held: cs_n=%b want 0", spiflash_cs_n); end
  endtask

  task automatic test_continuation();
    int lat, r0, c0; logic a, e; logic [31:0] obs, expd;
    r0 = sclk_rises; c0 = f_cmds;
    exp_q.push_back(32'h07060504);
    bus_cycle(1'b0, 22'h1, lat, a, e);
    checks++;
    if (!a || lat != CONT_LAT) begin failures++; $display("FAIL cont_latency: ack=%0b lat=%0d want %0d", a, lat, CONT_LAT); end
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (obs !== expd) begin failures++; $display("FAIL cont_data: got %h want %h", obs, expd); end
    checks++;
    if (f_cmds != c0 || sclk_rises - r0 != 32) begin
      failures++; $display("FAIL cont_no_cmd: new_cmds=%0d sclk=%0d want 0 32", f_cmds - c0, sclk_rises - r0);
    end
  endtask

  task automatic test_nonmatch();
    int lat; logic a, e; logic [31:0] obs, expd;
    exp_q.push_back(32'h43424140);
    bus_cycle(1'b0, 22'h100, lat, a, e);
    checks++;
    if (!a || lat != FRESH_LAT + CS_HIGH_MIN) begin
      failures++; $display("FAIL nonmatch_latency: ack=%0b lat=%0d want %0d", a, lat, FRESH_LAT + CS_HIGH_MIN);
    end
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (obs !== expd) begin failures++; $display("FAIL nonmatch_data: got %h want %h", obs, expd); end
    checks++;
    if (f_cmd !== 8'h03 || f_cmd_addr !== 24'h000400 || last_cs_high < CS_HIGH_MIN) begin
      failures++; $display("FAIL nonmatch_reselect: cmd=%h addr=%h cs_high=%0d want 03 000400 >=%0d",
                           f_cmd, f_cmd_addr, last_cs_high, CS_HIGH_MIN);
    end
  endtask

  task automatic test_hold_timeout();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (spiflash_cs_n !== 1'b1 && n < 200);
    checks++;
    if (n != HOLD_TIMEOUT) begin failures++; $display("FAIL hold_timeout: cs_n rose after %0d cycles want %0d", n, HOLD_TIMEOUT); end
    repeat (10) @(posedge sys_clk);
  endtask

  task automatic test_write_err();
    int lat, r0; logic a, e; logic [31:0] obs, expd;
    r0 = sclk_rises;
    bus_cycle(1'b1, 22'h2AAAA, lat, a, e);
    checks++;
    if (!e || a || lat != 2 || sclk_rises != r0) begin
      failures++; $display("FAIL write_err: err=%0b ack=%0b lat=%0d sclk=%0d want 1 0 2 0", e, a, lat, sclk_rises - r0);
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL write_no_ack: acks=%0d want 0", obs_q.size()); end
    exp_q.push_back(32'h03020100);
    bus_cycle(1'b0, 22'h0, lat, a, e);
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (!a || lat != FRESH_LAT || obs !== expd) begin
      failures++; $display("FAIL read_after_write: ack=%0b lat=%0d data=%h want 1 %0d %h", a, lat, obs, FRESH_LAT, expd);
    end
  endtask

  task automatic test_abort();
    int lat, r0, n; logic a, e; logic [31:0] obs, expd;
    repeat (HOLD_TIMEOUT + CS_HIGH_MIN + 8) @(posedge sys_clk);
    @(posedge sys_clk); #1;
    r0 = sclk_rises;
    wb_adr_i = 22'h5; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    while (sclk_rises - r0 < 20 && n < 500) begin @(negedge sys_clk); n++; end
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (n >= 500 || spiflash_clk !== 1'b0) begin failures++; $display("FAIL abort_clk_low: clk=%b wait=%0d want 0", spiflash_clk, n); end
    @(negedge sys_clk);
    checks++;
    if (spiflash_cs_n !== 1'b1) begin failures++; $display("FAIL abort_cs_high: cs_n=%b want 1", spiflash_cs_n); end
    repeat (20) @(posedge sys_clk);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL abort_no_ack: acks=%0d want 0", obs_q.size()); end
    exp_q.push_back(32'h03020100);
    bus_cycle(1'b0, 22'h0, lat, a, e);
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (!a || obs !== expd || f_cmd_addr !== 24'h0) begin
      failures++; $display("FAIL read_after_abort: ack=%0b data=%h addr=%h want 1 %h 000000", a, obs, f_cmd_addr, expd);
    end
  endtask

  task automatic test_wrap();
    int lat, c0; logic a, e; logic [31:0] obs, expd;
    exp_q.push_back(32'hF0F1F2F3);
    bus_cycle(1'b0, 22'h3FFFFF, lat, a, e);
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (!a || obs !== expd || f_cmd_addr !== 24'hFFFFFC) begin
      failures++; $display("FAIL wrap_top_read: ack=%0b data=%h addr=%h want 1 %h FFFFFC", a, obs, f_cmd_addr, expd);
    end
    bus_cycle(1'b1, 22'h0, lat, a, e);
    checks++;
    if (!e || a || lat != 2) begin failures++; $display("FAIL hold_write_err: err=%0b ack=%0b lat=%0d want 1 0 2", e, a, lat); end
    c0 = f_cmds;
    exp_q.push_back(32'h03020100);
    bus_cycle(1'b0, 22'h0, lat, a, e);
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (!a || lat != CONT_LAT || obs !== expd || f_cmds != c0) begin
      failures++; $display("FAIL wrap_continuation: ack=%0b lat=%0d data=%h new_cmds=%0d want 1 %0d %h 0",
                           a, lat, obs, f_cmds - c0, CONT_LAT, expd);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic a, e; logic [31:0] obs, expd;
    @(posedge sys_clk); #1;
    wb_adr_i = 22'h1; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (20) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({spiflash_cs_n, spiflash_clk, spiflash_mosi, wb_ack_o, wb_err_o, wb_dat_o} !== {5'b10000, 32'h0}) begin
      failures++;
      $display("FAIL async_reset: cs_n=%b clk=%b mosi=%b ack=%b err=%b dat=%h want 1 0 0 0 0 00000000",
               spiflash_cs_n, spiflash_clk, spiflash_mosi, wb_ack_o, wb_err_o, wb_dat_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
    exp_q.push_back(32'h0F0E0D0C);
    bus_cycle(1'b0, 22'h3, lat, a, e);
    checks++;
    expd = exp_q.pop_front(); obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    if (!a || lat != FRESH_LAT || obs !== expd) begin
      failures++; $display("FAIL read_after_reset: ack=%0b lat=%0d data=%h want 1 %0d %h", a, lat, obs, FRESH_LAT, expd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fresh_read();
    test_continuation();
    test_nonmatch();
    test_hold_timeout();
    test_write_err();
    test_abort();
    test_wrap();
    test_async_reset();
    repeat (5) @(posedge sys_clk);
    checks++;
    if (mode0_viol != 0) begin failures++; $display("FAIL mode0_mosi_stable: violations=%0d want 0", mode0_viol); end
    checks++;
    if (proto_viol != 0) begin failures++; $display("FAIL ack_err_protocol: violations=%0d want 0", proto_viol); end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: expected_left=%0d observed_left=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spiflash_wb_reader.md
Name: spiflash_wb_reader

Overview:
- Wishbone-classic slave that serves management-core instruction/data fetches from external SPI flash, using single-lane READ (0x03) in SPI mode 0.
- Drives the spiflash_cs_n / spiflash_clk / spiflash_mosi pins and samples spiflash_miso; sits directly upstream of the flash model in the SoC bench.
- Keeps CS low after a read so that a sequential next-word fetch skips the command and address phases.

Parameters:
- CLK_DIV, 1, SPI half-period in sys_clk cycles (≥1); SPI clock = sys_clk/(2*CLK_DIV).
- CS_HIGH_MIN, 4, minimum sys_clk cycles spiflash_cs_n stays high between transactions.
- HOLD_TIMEOUT, 32, idle sys_clk cycles in HOLD before CS is released.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- wb_adr_i  in  22  word address; flash byte address = {wb_adr_i, 2'b00}.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable; writes are not supported.
- wb_sel_i  in  4  byte selects, ignored for reads.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_err_o  out  1  single-cycle error for writes.
- spiflash_cs_n  out  1  chip select, active low.
- spiflash_clk  out  1  SPI clock, idles low.
- spiflash_mosi  out  1  serial data to flash.
- spiflash_miso  in  1  serial data from flash.

Behaviour:
- Reset (async, any state): cs_n=1, clk=0, mosi=0, ack=0, err=0, dat_o=0, state=DESEL with CS_HIGH_MIN counter loaded.
- Request = cyc & stb & ~ack & ~err. A write request gets err=1 for exactly one cycle, the cycle after it is seen, with no SPI activity.
- SPI mode 0:
  - mosi changes only while clk is low.
  - miso is sampled on the sys_clk edge that raises clk.
  - Bits are sent and received MSB first within each byte.
- States:
  - IDLE: cs_n=1. On a read request, latch addr and go to CMD the next cycle with cs_n=0 and mosi=bit 7 of 0x03.
  - CMD: 8 bits of 0x03, then ADDR.
  - ADDR: 24-bit byte address, MSB first, then DATA.
  - DATA: 32 bits. Flash byte k (k=0..3, in arrival order) goes to wb_dat_o[8k+7:8k], little-endian.
  - After the last rising edge of DATA: clk returns low. The next cycle sets ack=1 with dat_o valid. next_addr = addr+4 mod 2^24, then go to HOLD.
  - HOLD: cs_n=0, clk=0.
    - A read request with matching address goes to DATA, with no cmd/addr phase.
    - A read with a non-matching address, or the HOLD_TIMEOUT counter expiring, goes to DESEL.
    - A write in HOLD: err, stay in HOLD, counter restarts.
  - DESEL: cs_n=1 for CS_HIGH_MIN cycles. A pending read request then starts CMD directly; otherwise go to IDLE.
- Latency, from the cycle a request is first seen to ack (inclusive):
  - Fresh read: 2 + 128*CLK_DIV cycles.
  - Continuation from HOLD: 2 + 64*CLK_DIV cycles.
  - Read arriving in DESEL: add the remaining CS-high cycles.
- Abort: cyc dropping during CMD/ADDR/DATA forces clk=0 the next cycle, then DESEL. No ack is issued and the partial data is discarded.
- dat_o holds its last value between acks.
- Address wrap: next_addr from 0xFFFFFC is 0x000000, and continuation is still allowed because the flash wraps identically.
- ack and err are never asserted together and never for two consecutive cycles.

Decomposition:
- Package spiflash_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DATA, HOLD, DESEL);
  - constant CMD_READ = 8'h03;
  - FLASH_AW = 24 and WORD_W = 32.
- Sub-module spiflash_shifter:
  - contains the CLK_DIV divider, 32-bit shift-out/shift-in register and bit counter;
  - ports: start, nbits, tx word, rx word, done, abort;
  - the FSM in the top module sequences the shifter.

Test Plan:
- Flash bytes 00 01 02 03 at 0x000000. Read wb_adr_i=0 with CLK_DIV=1 -> exactly 0x03,0x00,0x00,0x00 on mosi, then dat_o=0x03020100, ack at cycle 130, cs_n stays 0.
- Then read wb_adr_i=1 (bytes 04..07) -> no cmd/addr bits, ack 66 cycles after the request, dat_o=0x07060504.
- From HOLD, read wb_adr_i=0x100 -> cs_n high for ≥4 cycles, then a fresh 0x03 + address 0x000400, ack at the fresh latency plus the CS-high time.
- Write request (we=1, any adr) -> err=1 for one cycle, ack=0, no spiflash_clk toggle; a following read behaves normally.
- Drop cyc after 20 SPI clocks -> clk low the next cycle, cs_n high within 2 cycles, no ack. The next read of wb_adr_i=0 returns 0x03020100.
- Read 0x3FFFFF, then 0x000000 -> the second read is a continuation with no command resent. Also: idle 32 cycles in HOLD -> cs_n rises. Also: assert sys_rst mid-DATA -> all outputs reach reset values asynchronously.
